// File: rtl/traffic_phase_ctrl.sv
// Two-direction traffic-light phase sequencer: one-second prescaler, fixed
// phase cycle with per-phase countdown, registered lamp decode, night flash.
//
// state     | meaning
// ----------+--------------------------------------------
// NS_GREEN  | north green, west red
// NS_YELLOW | north yellow, west red
// CLR_A     | all-red clearance before west green
// WE_GREEN  | west green, north red
// WE_YELLOW | west yellow, north red
// CLR_B     | all-red clearance before north green (reset state)
// FLASH     | night mode, both yellows blink, reds/greens off
module traffic_phase_ctrl #(
  parameter int TICK_CYCLES = 50_000_000,
  parameter int GREEN_S     = 30,
  parameter int YELLOW_S    = 3,
  parameter int ALL_RED_S   = 2,
  parameter int CNT_W       = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             en,
  input  logic             night_mode,
  output logic             north_red_time_pos,
  output logic             north_green_time_pos,
  output logic             north_yellow_time_pos,
  output logic             west_red_time_pos,
  output logic             west_green_time_pos,
  output logic             west_yellow_time_pos,
  output logic [CNT_W-1:0] remain_sec
);

  localparam int PW = (TICK_CYCLES > 1) ? $clog2(TICK_CYCLES) : 1;
  localparam logic [PW-1:0]    PRE_LAST = PW'(TICK_CYCLES - 1);
  localparam logic [CNT_W-1:0] DUR_G    = CNT_W'(GREEN_S);
  localparam logic [CNT_W-1:0] DUR_Y    = CNT_W'(YELLOW_S);
  localparam logic [CNT_W-1:0] DUR_R    = CNT_W'(ALL_RED_S);

  typedef enum logic [2:0] {
    NS_GREEN, NS_YELLOW, CLR_A, WE_GREEN, WE_YELLOW, CLR_B, FLASH
  } state_t;

  state_t           state, state_nxt, succ;
  logic [PW-1:0]    pre_cnt;
  logic             tick, pre_clr;
  logic             blink, blink_nxt;
  logic [CNT_W-1:0] remain_nxt, succ_dur;
  logic [5:0]       lamps_nxt;

  assign tick = en && (pre_cnt == PRE_LAST);

  always_comb begin
    succ     = CLR_B;
    succ_dur = DUR_R;
    unique case (state)
      NS_GREEN:  begin succ = NS_YELLOW; succ_dur = DUR_Y; end
      NS_YELLOW: begin succ = CLR_A;     succ_dur = DUR_R; end
      CLR_A:     begin succ = WE_GREEN;  succ_dur = DUR_G; end
      WE_GREEN:  begin succ = WE_YELLOW; succ_dur = DUR_Y; end
      WE_YELLOW: begin succ = CLR_B;     succ_dur = DUR_R; end
      CLR_B:     begin succ = NS_GREEN;  succ_dur = DUR_G; end
      default:   begin succ = CLR_B;     succ_dur = DUR_R; end
    endcase
  end

  // night_mode is checked before tick so it wins any same-cycle transition
  always_comb begin
    state_nxt  = state;
    remain_nxt = remain_sec;
    blink_nxt  = blink;
    pre_clr    = 1'b0;
    if (state == FLASH) begin
      if (!night_mode) begin
        state_nxt  = CLR_B;
        remain_nxt = DUR_R;
        blink_nxt  = 1'b0;
        pre_clr    = 1'b1;
      end else if (tick) begin
        blink_nxt = ~blink;
      end
    end else if (night_mode) begin
      state_nxt  = FLASH;
      remain_nxt = '0;
      blink_nxt  = 1'b1;
      pre_clr    = 1'b1;
    end else if (tick) begin
      if (remain_sec == CNT_W'(1)) begin
        state_nxt  = succ;
        remain_nxt = succ_dur;
      end else begin
        remain_nxt = remain_sec - CNT_W'(1);
      end
    end
  end

  // lamp order: north red/green/yellow, west red/green/yellow
  always_comb begin
    lamps_nxt = 6'b100_100;
    unique case (state_nxt)
      NS_GREEN:  lamps_nxt = 6'b010_100;
      NS_YELLOW: lamps_nxt = 6'b001_100;
      WE_GREEN:  lamps_nxt = 6'b100_010;
      WE_YELLOW: lamps_nxt = 6'b100_001;
      FLASH:     lamps_nxt = {2'b00, blink_nxt, 2'b00, blink_nxt};
      default:   lamps_nxt = 6'b100_100;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= CLR_B;
      remain_sec <= DUR_R;
      pre_cnt    <= '0;
      blink      <= 1'b0;
      {north_red_time_pos, north_green_time_pos, north_yellow_time_pos,
       west_red_time_pos, west_green_time_pos, west_yellow_time_pos} <= 6'b100_100;
    end else begin
      state      <= state_nxt;
      remain_sec <= remain_nxt;
      blink      <= blink_nxt;
      if (pre_clr)
        pre_cnt <= '0;
      else if (en)
        pre_cnt <= (pre_cnt == PRE_LAST) ? '0 : pre_cnt + PW'(1);
      {north_red_time_pos, north_green_time_pos, north_yellow_time_pos,
       west_red_time_pos, west_green_time_pos, west_yellow_time_pos} <= lamps_nxt;
    end
  end

endmodule
